// File: rtl/int_req_arb.sv
// int_req_arb -- interrupt request arbiter ahead of the interrupt controller.
//
// Edge-detects four synchronous request lines, holds them pending, and issues
// the highest-priority pending source whose level beats the current
// in-service level. An issue produces a one-cycle break/flush pulse with the
// 2-bit source code and the captured return PC. After each issue a guard
// window of GUARD cycles blocks further issues while the pipeline flushes.
//
// Ports
//   in_CLK       clock, rising edge
//   in_RST       synchronous active-high reset
//   in_IRQ[3:0]  raw requests (bit 3 highest priority), rising edge = request
//   in_NIE       global issue enable
//   in_stall     pipeline stall, blocks issue
//   in_PC        return address candidate
//   in_IG[3:0]   one-hot in-service clear (eret acknowledge)
//   out_BK       one-cycle break pulse per issue
//   out_code     source index of the current/last issue
//   out_EPC      in_PC captured at the issue decision
//   out_flush    copy of out_BK
//   out_pending  pending request register
//   out_inserv   in-service register

// Per-source cell: edge detector plus pending / in-service bits.
// A set always beats a clear landing on the same bit in the same cycle.
module int_req_arb_src (
  input  logic in_CLK,
  input  logic in_RST,
  input  logic irq,
  input  logic ig,
  input  logic iss,
  output logic pending,
  output logic inserv
);
  logic prev;
  logic edge_det;

  assign edge_det = irq & ~prev;

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      prev    <= 1'b0;
      pending <= 1'b0;
      inserv  <= 1'b0;
    end else begin
      prev    <= irq;
      pending <= edge_det | (pending & ~iss);
      inserv  <= iss | (inserv & ~ig);
    end
  end
endmodule

module int_req_arb #(
  parameter int GUARD = 2,
  parameter int PC_W  = 32
) (
  input  logic            in_CLK,
  input  logic            in_RST,
  input  logic [3:0]      in_IRQ,
  input  logic            in_NIE,
  input  logic            in_stall,
  input  logic [PC_W-1:0] in_PC,
  input  logic [3:0]      in_IG,
  output logic            out_BK,
  output logic [1:0]      out_code,
  output logic [PC_W-1:0] out_EPC,
  output logic            out_flush,
  output logic [3:0]      out_pending,
  output logic [3:0]      out_inserv
);
  localparam int NUM_SRC = 4;
  localparam logic [2:0] GCNT_INIT = 3'(GUARD - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD} state_t;

  state_t       state;
  logic [2:0]   gcnt;
  logic [1:0]   cand;      // highest pending source
  logic         cand_vld;
  logic [1:0]   lvl;       // highest in-service source
  logic         lvl_vld;   // 0 means level -1
  logic         issue;
  logic [NUM_SRC-1:0] iss_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      int_req_arb_src u_src (
        .in_CLK  (in_CLK),
        .in_RST  (in_RST),
        .irq     (in_IRQ[gi]),
        .ig      (in_IG[gi]),
        .iss     (iss_vec[gi]),
        .pending (out_pending[gi]),
        .inserv  (out_inserv[gi])
      );
    end
  endgenerate

  // Priority encoders on the registered vectors; eret clears in flight this
  // cycle are deliberately not looked at.
  always_comb begin
    cand     = 2'd0;
    cand_vld = 1'b0;
    lvl      = 2'd0;
    lvl_vld  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (out_pending[i]) begin
        cand     = 2'(i);
        cand_vld = 1'b1;
      end
      if (out_inserv[i]) begin
        lvl     = 2'(i);
        lvl_vld = 1'b1;
      end
    end
  end

  assign issue = (state == S_IDLE) && cand_vld && (!lvl_vld || cand > lvl)
                 && in_NIE && !in_stall;

  always_comb begin
    iss_vec = '0;
    if (issue) iss_vec[cand] = 1'b1;
  end

  // out_BK is registered so it rises together with code/EPC/inserv.
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state    <= S_IDLE;
      gcnt     <= 3'd0;
      out_BK   <= 1'b0;
      out_code <= 2'd0;
      out_EPC  <= '0;
    end else begin
      out_BK <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            out_code <= cand;
            out_EPC  <= in_PC;
            out_BK   <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          gcnt  <= GCNT_INIT;
          state <= S_GUARD;
        end
        S_GUARD: begin
          if (gcnt == 3'd0) state <= S_IDLE;
          else              gcnt  <= gcnt - 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_flush = out_BK;
endmodule

// File: tb/tb_int_req_arb.sv
module tb_int_req_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        nie;
  logic        stall;
  logic [31:0] pc;
  logic [3:0]  ig;
  logic        bk;
  logic [1:0]  code;
  logic [31:0] epc;
  logic        flush;
  logic [3:0]  pend;
  logic [3:0]  insv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  int_req_arb #(.GUARD(2), .PC_W(32)) dut (
    .in_CLK(clk), .in_RST(rst), .in_IRQ(irq), .in_NIE(nie), .in_stall(stall),
    .in_PC(pc), .in_IG(ig), .out_BK(bk), .out_code(code), .out_EPC(epc),
    .out_flush(flush), .out_pending(pend), .out_inserv(insv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each step ends 1 time unit after a rising edge: inputs driven here apply
  // to the next edge, outputs read here are the state for this cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_bk(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bk) hits++;
    end
    chk(tag, hits, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bk"}, {31'd0, bk}, 0);
    chk({tag, "_flush"}, {31'd0, flush}, 0);
    chk({tag, "_code"}, {30'd0, code}, 0);
    chk({tag, "_epc"}, epc, 0);
    chk({tag, "_pend"}, {28'd0, pend}, 0);
    chk({tag, "_insv"}, {28'd0, insv}, 0);
  endtask

  initial begin
    rst = 1'b1; irq = 4'h0; nie = 1'b1; stall = 1'b0; pc = 32'h0; ig = 4'h0;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;
    step(); step();

    // Single request: BK two cycles after the rising edge
    irq = 4'b0001; pc = 32'h100;
    step();
    chk("single_pend", {28'd0, pend}, 4'b0001);
    chk("single_nobk", {31'd0, bk}, 0);
    step();
    chk("single_bk", {31'd0, bk}, 1);
    chk("single_flush", {31'd0, flush}, 1);
    chk("single_code", {30'd0, code}, 0);
    chk("single_epc", epc, 32'h100);
    chk("single_insv", {28'd0, insv}, 4'b0001);
    chk("single_pend2", {28'd0, pend}, 4'b0000);
    pc = 32'h999;
    step();
    chk("single_bk_1cyc", {31'd0, bk}, 0);
    chk("single_epc_hold", epc, 32'h100);
    ig = 4'b0001;
    step();
    ig = 4'b0000;
    chk("single_ig", {28'd0, insv}, 4'b0000);
    irq = 4'b0000;
    step(); step(); step();

    // Priority: 2 beats 0; 0 waits for the eret of 2
    irq = 4'b0101; pc = 32'h200;
    step();
    chk("prio_pend", {28'd0, pend}, 4'b0101);
    step();
    chk("prio_bk", {31'd0, bk}, 1);
    chk("prio_code", {30'd0, code}, 2);
    chk("prio_insv", {28'd0, insv}, 4'b0100);
    chk("prio_pend2", {28'd0, pend}, 4'b0001);
    chk("prio_epc", epc, 32'h200);
    no_bk("prio_wait", 6);
    ig = 4'b0100; pc = 32'h204;
    step();
    ig = 4'b0000;
    chk("prio_ig", {28'd0, insv}, 4'b0000);
    chk("prio_ig_nobk", {31'd0, bk}, 0);
    step();
    chk("prio_bk2", {31'd0, bk}, 1);
    chk("prio_code2", {30'd0, code}, 0);
    chk("prio_epc2", epc, 32'h204);
    chk("prio_insv2", {28'd0, insv}, 4'b0001);
    ig = 4'b0001; irq = 4'b0000;
    step();
    ig = 4'b0000;
    step(); step(); step();

    // Nesting with exact guard spacing: 3 preempts 1, 0 waits for both
    irq = 4'b0010; pc = 32'h300;
    step(); step();
    chk("nest_bk1", {31'd0, bk}, 1);
    chk("nest_code1", {30'd0, code}, 1);
    chk("nest_insv1", {28'd0, insv}, 4'b0010);
    irq = 4'b1010; pc = 32'h310;
    step();
    chk("nest_g1", {31'd0, bk}, 0);
    chk("nest_pend3", {28'd0, pend}, 4'b1000);
    step();
    chk("nest_g2", {31'd0, bk}, 0);
    step();
    chk("nest_g3", {31'd0, bk}, 0);
    step();
    chk("nest_bk3", {31'd0, bk}, 1);
    chk("nest_code3", {30'd0, code}, 3);
    chk("nest_insv3", {28'd0, insv}, 4'b1010);
    chk("nest_epc3", epc, 32'h310);
    irq = 4'b1011;
    no_bk("nest_wait0a", 6);
    chk("nest_pend0", {28'd0, pend}, 4'b0001);
    ig = 4'b1000;
    step();
    ig = 4'b0000;
    chk("nest_ig3", {28'd0, insv}, 4'b0010);
    no_bk("nest_wait0b", 5);
    ig = 4'b0010;
    step();
    ig = 4'b0000;
    chk("nest_ig1_nobk", {31'd0, bk}, 0);
    step();
    chk("nest_bk0", {31'd0, bk}, 1);
    chk("nest_code0", {30'd0, code}, 0);
    chk("nest_insv0", {28'd0, insv}, 4'b0001);
    ig = 4'b0001; irq = 4'b0000;
    step();
    ig = 4'b0000;
    step(); step(); step();

    // Masking and stall
    nie = 1'b0; irq = 4'b0100; pc = 32'h400;
    no_bk("mask_nie", 11);
    chk("mask_pend", {28'd0, pend}, 4'b0100);
    nie = 1'b1; stall = 1'b1;
    no_bk("mask_stall", 4);
    chk("mask_pend2", {28'd0, pend}, 4'b0100);
    stall = 1'b0;
    step();
    chk("mask_bk", {31'd0, bk}, 1);
    chk("mask_code", {30'd0, code}, 2);
    chk("mask_epc", epc, 32'h400);
    ig = 4'b0100; irq = 4'b0000;
    step();
    ig = 4'b0000;
    step(); step(); step();

    // Collision: source 2 edge in its own issue cycle keeps it pending
    stall = 1'b1; irq = 4'b0100;
    step();
    chk("col1_pend", {28'd0, pend}, 4'b0100);
    irq = 4'b0000;
    step();
    irq = 4'b0100; stall = 1'b0; pc = 32'h500;
    step();
    chk("col1_bk", {31'd0, bk}, 1);
    chk("col1_code", {30'd0, code}, 2);
    chk("col1_pend_kept", {28'd0, pend}, 4'b0100);
    chk("col1_insv", {28'd0, insv}, 4'b0100);
    no_bk("col1_wait", 5);
    ig = 4'b0100;
    step();
    ig = 4'b0000;
    chk("col1_ig_nobk", {31'd0, bk}, 0);
    step();
    chk("col1_bk2", {31'd0, bk}, 1);
    chk("col1_pend2", {28'd0, pend}, 4'b0000);
    ig = 4'b0100;
    step();
    ig = 4'b0000;
    step(); step(); step();

    // Collision: eret clear of source 1 in its own issue cycle loses
    irq = 4'b0110; pc = 32'h600;
    step();
    chk("col2_pend", {28'd0, pend}, 4'b0010);
    ig = 4'b0010;
    step();
    ig = 4'b0000;
    chk("col2_bk", {31'd0, bk}, 1);
    chk("col2_code", {30'd0, code}, 1);
    chk("col2_insv", {28'd0, insv}, 4'b0010);

    // Reset during GUARD with source 3 pending and held high
    irq = 4'b1110;
    step();
    chk("rst_pre_pend", {28'd0, pend}, 4'b1000);
    chk("rst_pre_nobk", {31'd0, bk}, 0);
    rst = 1'b1;
    step();
    chk_zero("rst_mid");
    rst = 1'b0; pc = 32'h700;
    step();
    chk("rst_rel_nobk", {31'd0, bk}, 0);
    chk("rst_rel_pend", {28'd0, pend}, 4'b1110);
    step();
    chk("rst_bk", {31'd0, bk}, 1);
    chk("rst_code", {30'd0, code}, 3);
    chk("rst_epc", epc, 32'h700);
    no_bk("rst_once", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
